mm_lsu_port: RTL and testbench

LSU responder that services word/half/byte requests from the Montgomery multiplier accelerator and any other accelerator that speaks the lsu_ren/lsu_wen interface. It forms the effective address, posts writes into a small write buffer so a writer can issue one write per cycle, and serializes reads and write-buffer drains onto a single req/gnt/rvalid data-memory port. It sits between the accelerator and the data-memory arbiter.

---
 rtl/mm_lsu_port.sv | 207 ++++++++++++++++++++
 tb/tb_mm_lsu_port.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_lsu_port.sv
// mm_lsu_port: accelerator load/store responder.
// Posts writes into a FIFO and serializes reads and drains onto one port.
module mm_lsu_port #(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_type,
  input  logic [31:0] lsu_addr_base,
  input  logic [31:0] lsu_addr_offset,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_empty
);

  localparam int AW = $clog2(WB_DEPTH);
  localparam logic [1:0] DATA_WORD = 2'b00;
  localparam logic [1:0] DATA_HALF = 2'b01;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } wb_ent_t;

  rd_state_e     state_q, state_d;
  wb_ent_t       wb_q [WB_DEPTH];
  wb_ent_t       wb_d [WB_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   rd_ea_q, rd_ea_d;
  logic [1:0]    rd_type_q, rd_type_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0] ea;
  logic        is_byte, is_half, is_word;
  logic        misalign, idle, req_err;
  logic        wb_full, wb_emp;
  logic        push, pop, start_rd;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  assign ea = lsu_addr_base + lsu_addr_offset;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    unique case (1'b1)
      (lsu_type == DATA_WORD): is_word = 1'b1;
      (lsu_type == DATA_HALF): is_half = 1'b1;
      default:                 is_byte = 1'b1;
    endcase
  end

  assign misalign = (is_half & ea[0]) | (is_word & (|ea[1:0]));
  assign idle     = (state_q == RD_IDLE);
  assign wb_emp   = (cnt_q == '0);
  assign wb_full  = (cnt_q == (AW+1)'(WB_DEPTH));

  // ren+wen together is a protocol error, reported like a misalignment
  assign req_err  = idle & (lsu_ren | lsu_wen)
                  & (misalign | (lsu_ren & lsu_wen));
  assign push     = idle & lsu_wen & ~lsu_ren & ~misalign & ~wb_full;
  assign pop      = idle & ~wb_emp & mem_gnt;
  assign start_rd = idle & lsu_ren & ~lsu_wen & ~misalign & wb_emp;

  always_comb begin
    wr_be   = 4'h0;
    wr_data = '0;
    unique case (1'b1)
      is_word: begin
        wr_be   = 4'hF;
        wr_data = lsu_wdata;
      end
      is_half: begin
        wr_be   = 4'b0011 << ea[1:0];
        wr_data = {2{lsu_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b0001 << ea[1:0];
        wr_data = {4{lsu_wdata[7:0]}};
      end
    endcase
  end

  assign rd_shift = mem_rdata >> {rd_ea_q[1:0], 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    unique case (1'b1)
      (rd_type_q == DATA_WORD): rd_ext = rd_shift;
      (rd_type_q == DATA_HALF): rd_ext = {16'h0, rd_shift[15:0]};
      default:                  rd_ext = {24'h0, rd_shift[7:0]};
    endcase
  end

  always_comb begin
    wb_d = wb_q;
    if (push) begin
      wb_d[wr_ptr_q] = '{addr: ea[31:2], be: wr_be, wdata: wr_data};
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    state_d   = state_q;
    rd_ea_d   = rd_ea_q;
    rd_type_d = rd_type_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      RD_IDLE: begin
        if (start_rd) begin
          state_d   = RD_REQ;
          rd_ea_d   = ea;
          rd_type_d = lsu_type;
        end
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          state_d = RD_RESP;
          rdata_d = rd_ext;
        end
      end
      RD_RESP: state_d = RD_IDLE;
    endcase
  end

  // The read FSM owns the port while busy; drains only run from idle
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == RD_REQ) begin
      mem_req  = 1'b1;
      mem_be   = 4'hF;
      mem_addr = {rd_ea_q[31:2], 2'b00};
    end else if (idle && !wb_emp) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_be    = wb_q[rd_ptr_q].be;
      mem_addr  = {wb_q[rd_ptr_q].addr, 2'b00};
      mem_wdata = wb_q[rd_ptr_q].wdata;
    end
  end

  assign lsu_done  = rst_n & ((state_q == RD_RESP) | req_err | push);
  assign lsu_err   = rst_n & req_err;
  assign lsu_rdata = rdata_q;
  assign wb_empty  = wb_emp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RD_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_ea_q   <= '0;
      rd_type_q <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_ea_q   <= rd_ea_d;
      rd_type_q <= rd_type_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_q[i] <= wb_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mm_lsu_port.sv
// tb_mm_lsu_port: directed table-driven bench for mm_lsu_port.
// Memory model logs granted writes and answers reads one cycle after gnt.
module tb_mm_lsu_port;

  localparam logic [1:0] TW = 2'b00;
  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TB = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_ren = 1'b0;
  logic        lsu_wen = 1'b0;
  logic [1:0]  lsu_type = TW;
  logic [31:0] lsu_addr_base = '0;
  logic [31:0] lsu_addr_offset = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_empty;

  logic        gnt = 1'b1;
  logic        rv_en = 1'b1;
  logic        stray_rv = 1'b0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [31:0] merged;
  int          rd_grant_n = -1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  int n_chk = 0;
  int n_err = 0;

  assign mem_gnt    = gnt;
  assign mem_rvalid = rv_q | stray_rv;
  assign mem_rdata  = rd_q;

  always #5 clk = ~clk;

  mm_lsu_port #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type),
    .lsu_addr_base(lsu_addr_base), .lsu_addr_offset(lsu_addr_offset),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_empty(wb_empty)
  );

  always_comb begin
    merged = mem[mem_addr[11:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    rv_q <= mem_req && mem_gnt && !mem_we && rv_en;
    rd_q <= mem[mem_addr[11:2]];
    if (mem_req && mem_gnt && mem_we) begin
      mem[mem_addr[11:2]] <= merged;
      wlog.push_back('{mem_addr, mem_be, mem_wdata});
    end
    if (mem_req && mem_gnt && !mem_we) rd_grant_n <= wlog.size();
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] t,
                       input logic [31:0] b, input logic [31:0] o,
                       input logic [31:0] d);
    lsu_ren = r;
    lsu_wen = w;
    lsu_type = t;
    lsu_addr_base = b;
    lsu_addr_offset = o;
    lsu_wdata = d;
  endtask

  task automatic idle_in();
    lsu_ren = 1'b0;
    lsu_wen = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int c = 0;
    while (!wb_empty && c < 20) begin
      cyc();
      c++;
    end
    chk(nm, 32'(wb_empty), 32'd1);
  endtask

  task automatic wait_done(output logic [31:0] d, output int lat);
    lat = -1;
    d = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lsu_done) begin
        lat = c;
        d = lsu_rdata;
        break;
      end
      cyc();
    end
    cyc();
    idle_in();
  endtask

  task automatic check_log(input string nm, input int idx0, input int n,
                           input logic [31:0] abase,
                           input logic [31:0] dbase);
    chk({nm, " cnt"}, 32'(wlog.size() - idx0), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (idx0 + i < wlog.size()) begin
        chk($sformatf("%s a%0d", nm, i), wlog[idx0+i].addr, abase + 4*i);
        chk($sformatf("%s d%0d", nm, i), wlog[idx0+i].data, dbase + i);
        chk($sformatf("%s be%0d", nm, i), 32'(wlog[idx0+i].be), 32'hF);
      end
    end
  endtask

  typedef struct {
    logic        ren;
    logic        wen;
    logic [1:0]  t;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wd;
    logic        done;
    logic        err;
    logic        req;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] mwd;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [31:0] d;
    int lat;
    int idx0;

    vt[0] = '{1'b0, 1'b1, TW, 32'h100, 32'h0, 32'hDEADBEEF,
              1'b1, 1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b1, TB, 32'h100, 32'h3, 32'h000000A5,
              1'b1, 1'b0, 1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5};
    vt[2] = '{1'b0, 1'b1, TH, 32'h1FE, 32'h4, 32'h00001234,
              1'b1, 1'b0, 1'b1, 4'b1100, 32'h200, 32'h12341234};
    vt[3] = '{1'b0, 1'b1, TB, 32'hFFFFFFFF, 32'h2, 32'hFFFFFF5A,
              1'b1, 1'b0, 1'b1, 4'b0010, 32'h0, 32'h5A5A5A5A};
    vt[4] = '{1'b0, 1'b1, TW, 32'h3F0, 32'h10, 32'h1234ABCD,
              1'b1, 1'b0, 1'b1, 4'hF, 32'h400, 32'h1234ABCD};
    vt[5] = '{1'b1, 1'b0, TW, 32'h100, 32'h2, 32'h0,
              1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vt[6] = '{1'b0, 1'b1, TH, 32'h100, 32'h1, 32'h0,
              1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vt[7] = '{1'b1, 1'b1, TW, 32'h100, 32'h0, 32'h0,
              1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vt[8] = '{1'b0, 1'b1, TB, 32'h200, 32'h0, 32'h11223344,
              1'b1, 1'b0, 1'b1, 4'b0001, 32'h200, 32'h44444444};

    // reset values
    repeat (3) cyc();
    @(negedge clk);
    chk("rst done", 32'(lsu_done), 32'd0);
    chk("rst err", 32'(lsu_err), 32'd0);
    chk("rst rdata", lsu_rdata, 32'd0);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst we", 32'(mem_we), 32'd0);
    chk("rst be", 32'(mem_be), 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst wb_empty", 32'(wb_empty), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // single-request vectors, gnt tied high
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].ren, vt[i].wen, vt[i].t, vt[i].base, vt[i].off, vt[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d done", i), 32'(lsu_done), 32'(vt[i].done));
      chk($sformatf("v%0d err", i), 32'(lsu_err), 32'(vt[i].err));
      cyc();
      idle_in();
      @(negedge clk);
      chk($sformatf("v%0d req", i), 32'(mem_req), 32'(vt[i].req));
      if (vt[i].req) begin
        chk($sformatf("v%0d we", i), 32'(mem_we), 32'd1);
        chk($sformatf("v%0d be", i), 32'(mem_be), 32'(vt[i].be));
        chk($sformatf("v%0d addr", i), mem_addr, vt[i].addr);
        chk($sformatf("v%0d wdata", i), mem_wdata, vt[i].mwd);
      end
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d empty", i), 32'(wb_empty), 32'd1);
      cyc();
    end

    // 8 back-to-back word writes, one per cycle
    idx0 = wlog.size();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, TW, 32'h200, 32'(4*i), 32'hA0000000 + 32'(i));
      @(negedge clk);
      chk($sformatf("b2b done%0d", i), 32'(lsu_done), 32'd1);
      cyc();
    end
    idle_in();
    wait_empty("b2b empty");
    check_log("b2b", idx0, 8, 32'h200, 32'hA0000000);

    // fill buffer with gnt low, then release
    gnt = 1'b0;
    idx0 = wlog.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, TW, 32'h300, 32'(4*i), 32'h50 + 32'(i));
      @(negedge clk);
      chk($sformatf("fill done%0d", i), 32'(lsu_done), 32'd1);
      cyc();
    end
    drive(1'b0, 1'b1, TW, 32'h300, 32'h10, 32'h54);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("full stall%0d", k), 32'(lsu_done), 32'd0);
      chk($sformatf("full head%0d", k), mem_addr, 32'h300);
      cyc();
    end
    gnt = 1'b1;
    @(negedge clk);
    chk("full pop blk", 32'(lsu_done), 32'd0);
    cyc();
    @(negedge clk);
    chk("full accept4", 32'(lsu_done), 32'd1);
    cyc();
    drive(1'b0, 1'b1, TW, 32'h300, 32'h14, 32'h55);
    @(negedge clk);
    chk("full accept5", 32'(lsu_done), 32'd1);
    cyc();
    idle_in();
    wait_empty("full empty");
    check_log("full", idx0, 6, 32'h300, 32'h50);

    // read waits behind a buffered write
    gnt = 1'b0;
    idx0 = wlog.size();
    drive(1'b0, 1'b1, TW, 32'h100, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    chk("raw wr done", 32'(lsu_done), 32'd1);
    cyc();
    drive(1'b1, 1'b0, TW, 32'h100, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("raw hold%0d", k), {30'h0, mem_req, mem_we}, 32'd3);
      cyc();
    end
    gnt = 1'b1;
    wait_done(d, lat);
    chk("raw timeout", 32'(lat >= 0), 32'd1);
    chk("raw rdata", d, 32'hDEADBEEF);
    chk("raw order", 32'(rd_grant_n), 32'(idx0 + 1));

    // zero-wait reads: latency and lane extraction
    drive(1'b1, 1'b0, TH, 32'h400, 32'h2, 32'h0);
    wait_done(d, lat);
    chk("rd half lat", 32'(lat), 32'd3);
    chk("rd half data", d, 32'h00001234);
    drive(1'b1, 1'b0, TB, 32'h3FF, 32'h2, 32'h0);
    wait_done(d, lat);
    chk("rd byte lat", 32'(lat), 32'd3);
    chk("rd byte data", d, 32'h000000AB);
    cyc();

    // reset while waiting for rvalid, then a stray rvalid
    rv_en = 1'b0;
    drive(1'b1, 1'b0, TW, 32'h400, 32'h0, 32'h0);
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) begin
        lat = c;
        break;
      end
      cyc();
    end
    chk("rwait req seen", 32'(lat >= 0), 32'd1);
    cyc();
    @(negedge clk);
    chk("rwait no req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("mrst done", 32'(lsu_done), 32'd0);
    chk("mrst err", 32'(lsu_err), 32'd0);
    chk("mrst rdata", lsu_rdata, 32'd0);
    chk("mrst req", 32'(mem_req), 32'd0);
    chk("mrst we", 32'(mem_we), 32'd0);
    chk("mrst be", 32'(mem_be), 32'd0);
    chk("mrst addr", mem_addr, 32'd0);
    chk("mrst wdata", mem_wdata, 32'd0);
    chk("mrst wb_empty", 32'(wb_empty), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    stray_rv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray done%0d", k), 32'(lsu_done), 32'd0);
      chk($sformatf("stray req%0d", k), 32'(mem_req), 32'd0);
      cyc();
      stray_rv = 1'b0;
    end
    chk("stray rdata", lsu_rdata, 32'd0);
    rv_en = 1'b1;

    // reset discards buffered writes
    gnt = 1'b0;
    idx0 = wlog.size();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, TW, 32'h500, 32'(4*i), 32'h70 + 32'(i));
      @(negedge clk);
      chk($sformatf("flush wr%0d", i), 32'(lsu_done), 32'd1);
      cyc();
    end
    idle_in();
    @(negedge clk);
    chk("flush pending", 32'(wb_empty), 32'd0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("flush empty", 32'(wb_empty), 32'd1);
    chk("flush req", 32'(mem_req), 32'd0);
    cyc();
    rst_n = 1'b1;
    gnt = 1'b1;
    repeat (3) cyc();
    chk("flush no wr", 32'(wlog.size() - idx0), 32'd0);
    chk("flush idle req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
